div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq.sv | 128 ++++++++++++
 tb/tb_div_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, handshake levels
// and the EX-stage aluop codes that route result_o into HI/LO.
package div_seq_pkg;

  localparam int REG_BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DIVZERO = 2'b01,
    ST_ON      = 2'b10,
    ST_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage: 32 iterations per divide,
// result held as {remainder, quotient} while the pipeline keeps start_i high.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [64:0]  sh_q, sh_d;
  logic [31:0]  divisor_q, divisor_d;
  logic         neg1_q, neg1_d;
  logic         neg2_q, neg2_d;
  logic [63:0]  res_q, res_d;

  logic [33:0]  diff;
  logic         ge;
  logic [64:0]  step;
  logic [31:0]  quo_fix;
  logic [31:0]  rem_fix;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    diff    = sh_q[64:31] - {2'b00, divisor_q};
    ge      = ~diff[33];
    step    = {(ge ? diff[32:0] : sh_q[63:31]), sh_q[30:0], ge};
    quo_fix = (neg1_q ^ neg2_q) ? neg32(step[31:0]) : step[31:0];
    rem_fix = neg1_q ? neg32(step[63:32]) : step[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    res_d     = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i == DIV_START && !annul_i) begin
          sh_d      = {33'd0, mag32(opdata1_i, signed_i)};
          divisor_d = mag32(opdata2_i, signed_i);
          neg1_d    = signed_i & opdata1_i[31];
          neg2_d    = signed_i & opdata2_i[31];
          cnt_d     = 6'd0;
          state_d   = (opdata2_i == 32'd0) ? ST_DIVZERO : ST_ON;
        end
      end
      ST_DIVZERO: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          res_d   = 64'd0;
          state_d = ST_END;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else begin
          sh_d = step;
          if (cnt_q == 6'd31) begin
            res_d   = {rem_fix, quo_fix};
            cnt_d   = 6'd0;
            state_d = ST_END;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_END: begin
        if (annul_i || start_i == DIV_STOP) begin
          res_d   = 64'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      sh_q      <= 65'd0;
      divisor_q <= 32'd0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      res_q     <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    ready_o    = (state_q == ST_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    result_o   = (state_q == ST_END) ? res_q : 64'd0;
    stallreq_o = !rst && ((state_q == ST_ON) || (state_q == ST_DIVZERO) ||
                          (state_q == ST_IDLE && start_i == DIV_START && !annul_i));
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results queued at issue, compared at ready_o.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    if (push) sb_q.push_back(model(a, b, s));
  endtask

  // Called at the negedge of cycle 0; returns latency in cycles or -1 on timeout.
  task automatic wait_ready(input int scramble_at, output int lat, output bit stall_ok, output bit zero_ok);
    lat      = -1;
    stall_ok = 1'b1;
    zero_ok  = 1'b1;
    #1;
    stall_ok &= stallreq_o;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == scramble_at) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~signed_i;
      end
      if (ready_o) begin
        lat = k;
        return;
      end
      stall_ok &= stallreq_o;
      zero_ok  &= (result_o == 64'd0);
    end
  endtask

  task automatic pop_expected(output logic [63:0] e);
    if (sb_q.size() == 0) e = 64'hDEAD_BEEF_DEAD_BEEF;
    else e = sb_q.pop_front();
  endtask

  task automatic release_start();
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] zero;
    zero = 64'd0;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    checks++;
    if (result_o !== zero) begin failures++; $display("FAIL reset_result got=%h want=%h", result_o, zero); end
    start_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stallreq_o); end
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat; bit sok, zok; logic [63:0] e;
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_ready(0, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL u100_7_latency got=%0d want=33", lat); end
    checks++;
    if (!sok) begin failures++; $display("FAIL u100_7_stall got=0 want=1 during cycles 0-32"); end
    checks++;
    if (!zok) begin failures++; $display("FAIL u100_7_result_zero_before_ready got=nonzero want=0"); end
    checks++;
    if (result_o !== e || e !== {32'd2, 32'd14}) begin failures++; $display("FAIL u100_7_result got=%h want=%h", result_o, {32'd2, 32'd14}); end
    checks++;
    if (stallreq_o !== 1'b0) begin failures++; $display("FAIL end_stall got=%b want=0", stallreq_o); end
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== e) begin failures++; $display("FAIL end_hold got=%b/%h want=1/%h", ready_o, result_o, e); end
    release_start();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin failures++; $display("FAIL end_release got=%b/%h want=0/0", ready_o, result_o); end
  endtask

  task automatic test_signed();
    int lat; bit sok, zok; logic [63:0] e;
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_ready(5, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33 || result_o !== e) begin failures++; $display("FAIL s_m7_2 got=%h lat=%0d want=%h lat=33", result_o, lat, e); end
    release_start();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    wait_ready(12, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33 || result_o !== e) begin failures++; $display("FAIL s_7_m2 got=%h lat=%0d want=%h lat=33", result_o, lat, e); end
    release_start();
  endtask

  task automatic test_divzero();
    int lat; bit sok, zok; logic [63:0] e;
    issue(32'h1234_5678, 32'd0, 1'b0, 1'b1);
    wait_ready(0, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL divzero_latency got=%0d want=2", lat); end
    checks++;
    if (result_o !== e || !sok) begin failures++; $display("FAIL divzero_result got=%h stall_ok=%b want=%h stall_ok=1", result_o, sok, e); end
    release_start();
  endtask

  task automatic test_overflow();
    int lat; bit sok, zok; logic [63:0] e;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_ready(0, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33 || result_o !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL s_ovf got=%h want=%h model=%h", result_o, 64'h0000_0000_8000_0000, e); end
    release_start();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_ready(0, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33 || result_o !== e) begin failures++; $display("FAIL u_max_1 got=%h want=%h", result_o, e); end
    release_start();
  endtask

  task automatic test_annul();
    int lat; bit sok, zok, seen; logic [63:0] e;
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (stallreq_o !== 1'b1) begin failures++; $display("FAIL annul_pre_stall got=%b want=1", stallreq_o); end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    checks++;
    if (stallreq_o !== 1'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL annul_idle got=stall %b ready %b want=0 0", stallreq_o, ready_o); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen |= ready_o;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL annul_no_ready got=1 want=0"); end
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    wait_ready(0, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33 || result_o !== {32'd0, 32'd3}) begin failures++; $display("FAIL annul_then_9_3 got=%h lat=%0d want=%h lat=33", result_o, lat, {32'd0, 32'd3}); end
    release_start();
  endtask

  task automatic test_reset_mid();
    int lat; bit sok, zok; logic [63:0] e;
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid got=ready %b result %h stall %b want=0 0 0", ready_o, result_o, stallreq_o);
    end
    rst = 1'b0;
    sb_q.push_back(model(32'd100, 32'd7, 1'b0));
    wait_ready(0, lat, sok, zok);
    pop_expected(e);
    checks++;
    if (lat !== 33 || result_o !== e) begin failures++; $display("FAIL reset_restart got=%h lat=%0d want=%h lat=33", result_o, lat, e); end
    release_start();
  endtask

  task automatic test_back_to_back();
    int lat; bit sok, zok; logic [63:0] e;
    logic [31:0] a, b; logic s;
    for (int n = 0; n < 6; n++) begin
      a = $urandom;
      b = (n == 2) ? 32'd0 : ((n % 2 == 0) ? $urandom : ($urandom & 32'h0000_FFFF));
      s = n[0];
      issue(a, b, s, 1'b1);
      wait_ready(0, lat, sok, zok);
      pop_expected(e);
      checks++;
      if (lat !== ((b == 32'd0) ? 2 : 33) || result_o !== e || !sok) begin
        failures++; $display("FAIL b2b_%0d a=%h b=%h s=%b got=%h lat=%0d want=%h", n, a, b, s, result_o, lat, e);
      end
      release_start();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_overflow();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_empty got=%0d want=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
